multicycle_controller: RTL and testbench

Multi-cycle control FSM that sequences the CPU datapath around the ALU. Each instruction runs through FETCH, DECODE, EXEC, MEM and WB as its class requires. In each state the block drives the ALU configuration (`ALUOp`, `ALUSrc`, `I_format`, `Sftmd`), PC/IR/register-file/memory enables and the PC source select. It handshakes with instruction/data memory via `mem_ready` and counts retired instructions.

---
 rtl/multicycle_controller_pkg.sv | 62 ++++++
 rtl/multicycle_controller_if.sv | 39 +++
 rtl/multicycle_controller_decode.sv | 36 +++
 rtl/multicycle_controller.sv | 158 +++++++++++++++
 tb/tb_multicycle_controller.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller: state encoding, opcode/funct
// constants, ALUOp and PC_src codes, and the one-hot instruction class vector.
`timescale 1ns/1ps
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_SUB  = 2'b01,
    ALU_FUNC = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_REG    = 2'b11
  } pc_src_e;

  // shift is a refinement of rtype: a shift instruction sets both bits.
  typedef struct packed {
    logic illegal;
    logic jal;
    logic j;
    logic bne;
    logic beq;
    logic sw;
    logic lw;
    logic ialu;
    logic jr;
    logic shift;
    logic rtype;
  } instr_class_t;

  function automatic logic is_ialu_op(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. The controller is the master: it
// consumes IR fields and status, and drives every datapath enable.
`timescale 1ns/1ps
interface multicycle_controller_if #(parameter int CNT_W = 32);
  logic [5:0]       Opcode;
  logic [5:0]       Function_opcode;
  logic             Zero;
  logic             mem_ready;
  logic             PC_write;
  logic [1:0]       PC_src;
  logic             IR_write;
  logic             MemRead;
  logic             MemWrite;
  logic             IorD;
  logic             RegWrite;
  logic             MemtoReg;
  logic             Jal;
  logic [1:0]       ALUOp;
  logic             ALUSrc;
  logic             I_format;
  logic             Sftmd;
  logic             retire;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Opcode, Function_opcode, Zero, mem_ready,
    output PC_write, PC_src, IR_write, MemRead, MemWrite, IorD, RegWrite,
           MemtoReg, Jal, ALUOp, ALUSrc, I_format, Sftmd, retire, illegal,
           instr_count
  );

  modport slave (
    output Opcode, Function_opcode, Zero, mem_ready,
    input  PC_write, PC_src, IR_write, MemRead, MemWrite, IorD, RegWrite,
           MemtoReg, Jal, ALUOp, ALUSrc, I_format, Sftmd, retire, illegal,
           instr_count
  );
endinterface

// File: rtl/multicycle_controller_decode.sv
// Combinational opcode/funct to one-hot instruction class mapping.
`timescale 1ns/1ps
module multicycle_controller_decode
  import multicycle_controller_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_t class_o
);

  // NOTE: the output gets a default before any branch, so no path can leave a latch.
  always_comb begin
    class_o = '0;
    if (opcode_i == OP_RTYPE) begin
      if (funct_i == FN_JR) begin
        class_o.jr = 1'b1;
      end else begin
        class_o.rtype = 1'b1;
        class_o.shift = funct_i inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV};
      end
    end else if (is_ialu_op(opcode_i)) begin
      class_o.ialu = 1'b1;
    end else begin
      case (opcode_i)
        OP_LW:   class_o.lw      = 1'b1;
        OP_SW:   class_o.sw      = 1'b1;
        OP_BEQ:  class_o.beq     = 1'b1;
        OP_BNE:  class_o.bne     = 1'b1;
        OP_J:    class_o.j       = 1'b1;
        OP_JAL:  class_o.jal     = 1'b1;
        default: class_o.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath enables and ALU configuration, and counts retired instructions.
`timescale 1ns/1ps
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                   clock,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  state_e           state_q, state_d;
  instr_class_t     class_q, class_d, dec_class;
  logic [CNT_W-1:0] instr_count_q, instr_count_d;

  logic       pc_write, ir_write, mem_read, mem_write, iord, reg_write;
  logic       memtoreg, jal, alu_src, i_format, sftmd, retire, illegal;
  logic [1:0] pc_src, alu_op;

  multicycle_controller_decode u_decode (
    .opcode_i (bus.Opcode),
    .funct_i  (bus.Function_opcode),
    .class_o  (dec_class)
  );

  // NOTE: registers update with <= so every flop samples the pre-edge values.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      class_q       <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      class_q       <= class_d;
      instr_count_q <= instr_count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    pc_write  = 1'b0;
    pc_src    = PC_SEQ;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    reg_write = 1'b0;
    memtoreg  = 1'b0;
    jal       = 1'b0;
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    i_format  = 1'b0;
    sftmd     = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      // The class is captured here once and held for the rest of the instruction.
      S_DECODE: begin
        class_d = dec_class;
        if (dec_class.illegal) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        if (class_q.illegal) begin
          state_d = S_FETCH;
        end else if (class_q.rtype || class_q.ialu) begin
          alu_op   = ALU_FUNC;
          alu_src  = class_q.ialu;
          i_format = class_q.ialu;
          sftmd    = class_q.shift;
          state_d  = S_WB;
        end else if (class_q.lw || class_q.sw) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (class_q.beq || class_q.bne) begin
          alu_op   = ALU_SUB;
          pc_write = (class_q.beq && bus.Zero) || (class_q.bne && !bus.Zero);
          pc_src   = PC_BRANCH;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (class_q.j || class_q.jr) begin
          pc_write = 1'b1;
          pc_src   = class_q.jr ? PC_REG : PC_JUMP;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if (class_q.jal) begin
          pc_write = 1'b1;
          pc_src   = PC_JUMP;
          state_d  = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM: begin
        iord      = 1'b1;
        mem_read  = class_q.lw;
        mem_write = class_q.sw;
        if (bus.mem_ready) begin
          if (class_q.lw) begin
            state_d = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        memtoreg  = class_q.lw;
        jal       = class_q.jal;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign instr_count_d = retire ? instr_count_q + CNT_W'(1) : instr_count_q;

  assign bus.PC_write    = pc_write;
  assign bus.PC_src      = pc_src;
  assign bus.IR_write    = ir_write;
  assign bus.MemRead     = mem_read;
  assign bus.MemWrite    = mem_write;
  assign bus.IorD        = iord;
  assign bus.RegWrite    = reg_write;
  assign bus.MemtoReg    = memtoreg;
  assign bus.Jal         = jal;
  assign bus.ALUOp       = alu_op;
  assign bus.ALUSrc      = alu_src;
  assign bus.I_format    = i_format;
  assign bus.Sftmd       = sftmd;
  assign bus.retire      = retire;
  assign bus.illegal     = illegal;
  assign bus.instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the stimulus side builds each
// instruction's expected per-cycle control trace from the class rules.
`timescale 1ns/1ps
module tb_multicycle_controller;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       memtoreg;
    logic       jal;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       i_format;
    logic       sftmd;
    logic       retire;
    logic       illegal;
  } ctl_t;

  typedef struct {
    string       name;
    ctl_t        ctl;
    logic [31:0] count;
    bit          check;
  } exp_t;

  localparam int C_RTYPE = 0, C_SHIFT = 1, C_JR = 2, C_IALU = 3, C_LW = 4, C_SW = 5;
  localparam int C_BEQ = 6, C_BNE = 7, C_J = 8, C_JAL = 9, C_ILL = 10;

  logic clock = 1'b0;
  logic rst_n = 1'b0;

  multicycle_controller_if #(.CNT_W(32)) bus();

  multicycle_controller #(.CNT_W(32)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  exp_t        sb[$];
  int          n_checks  = 0;
  int          n_fail    = 0;
  logic [31:0] model_cnt = '0;
  bit          noise     = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference classification straight from the opcode/funct rules.
  function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      if (fn == 6'h08) return C_JR;
      if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || fn == 6'h04 ||
          fn == 6'h06 || fn == 6'h07) return C_SHIFT;
      return C_RTYPE;
    end
    if (op >= 6'h08 && op <= 6'h0F) return C_IALU;
    if (op == 6'h23) return C_LW;
    if (op == 6'h2B) return C_SW;
    if (op == 6'h04) return C_BEQ;
    if (op == 6'h05) return C_BNE;
    if (op == 6'h02) return C_J;
    if (op == 6'h03) return C_JAL;
    return C_ILL;
  endfunction

  function automatic logic [5:0] junk(input logic [5:0] v);
    return noise ? 6'($urandom) : v;
  endfunction

  function automatic logic rnd_bit(input logic v);
    return noise ? 1'($urandom) : v;
  endfunction

  // Monitor: pops one expected record per cycle and compares away from the edge.
  initial begin
    forever begin
      exp_t e;
      ctl_t a;
      @(negedge clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        a.pc_write  = bus.PC_write;
        a.pc_src    = bus.PC_src;
        a.ir_write  = bus.IR_write;
        a.mem_read  = bus.MemRead;
        a.mem_write = bus.MemWrite;
        a.iord      = bus.IorD;
        a.reg_write = bus.RegWrite;
        a.memtoreg  = bus.MemtoReg;
        a.jal       = bus.Jal;
        a.alu_op    = bus.ALUOp;
        a.alu_src   = bus.ALUSrc;
        a.i_format  = bus.I_format;
        a.sftmd     = bus.Sftmd;
        a.retire    = bus.retire;
        a.illegal   = bus.illegal;
        if (e.check) begin
          check({e.name, " ctl"}, 64'(a), 64'(e.ctl));
          check({e.name, " instr_count"}, 64'(bus.instr_count), 64'(e.count));
        end
      end
    end
  end

  task automatic step(input string nm, input bit chk, input logic rv, input logic mr,
                      input logic z, input logic [5:0] op, input logic [5:0] fn,
                      input ctl_t e);
    exp_t x;
    @(posedge clock);
    #1;
    rst_n               = rv;
    bus.mem_ready       = mr;
    bus.Zero            = z;
    bus.Opcode          = op;
    bus.Function_opcode = fn;
    x.name  = nm;
    x.ctl   = e;
    x.count = model_cnt;
    x.check = chk;
    sb.push_back(x);
    if (!rv) model_cnt = '0;
    else if (e.retire) model_cnt = model_cnt + 1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int wf, input int wm, input bit abort_mem);
    int   c;
    ctl_t e;
    bit   br;
    c  = classify(op, fn);
    br = (c == C_BEQ) || (c == C_BNE);

    for (int i = 0; i < wf; i++) begin
      e = '0; e.mem_read = 1'b1;
      step("fetch_wait", 1'b1, 1'b1, 1'b0, rnd_bit(z), junk(op), junk(fn), e);
    end
    e = '0; e.mem_read = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    step("fetch", 1'b1, 1'b1, 1'b1, rnd_bit(z), junk(op), junk(fn), e);

    e = '0;
    if (c == C_ILL) begin
      e.illegal = 1'b1;
      step("decode_illegal", 1'b1, 1'b1, rnd_bit(1'b1), rnd_bit(z), op, fn, e);
      return;
    end
    step("decode", 1'b1, 1'b1, rnd_bit(1'b1), rnd_bit(z), op, fn, e);

    e = '0;
    case (c)
      C_RTYPE, C_SHIFT: begin e.alu_op = 2'b10; e.sftmd = (c == C_SHIFT); end
      C_IALU:           begin e.alu_op = 2'b10; e.alu_src = 1'b1; e.i_format = 1'b1; end
      C_LW, C_SW:       e.alu_src = 1'b1;
      C_BEQ, C_BNE: begin
        e.alu_op   = 2'b01;
        e.pc_src   = 2'b01;
        e.pc_write = (c == C_BEQ) ? z : !z;
        e.retire   = 1'b1;
      end
      C_J:   begin e.pc_write = 1'b1; e.pc_src = 2'b10; e.retire = 1'b1; end
      C_JR:  begin e.pc_write = 1'b1; e.pc_src = 2'b11; e.retire = 1'b1; end
      C_JAL: begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      default: ;
    endcase
    step("exec", 1'b1, 1'b1, rnd_bit(1'b1), br ? z : rnd_bit(z), junk(op), junk(fn), e);
    if (e.retire) return;

    if (c == C_LW || c == C_SW) begin
      e = '0; e.iord = 1'b1; e.mem_read = (c == C_LW); e.mem_write = (c == C_SW);
      for (int i = 0; i < wm; i++)
        step("mem_wait", 1'b1, 1'b1, 1'b0, rnd_bit(z), junk(op), junk(fn), e);
      if (abort_mem) begin
        step("mem_reset", 1'b1, 1'b0, 1'b0, rnd_bit(z), junk(op), junk(fn), e);
        return;
      end
      e.retire = (c == C_SW);
      step("mem", 1'b1, 1'b1, 1'b1, rnd_bit(z), junk(op), junk(fn), e);
      if (c == C_SW) return;
    end

    e = '0; e.reg_write = 1'b1; e.memtoreg = (c == C_LW); e.jal = (c == C_JAL); e.retire = 1'b1;
    step("wb", 1'b1, 1'b1, rnd_bit(1'b1), rnd_bit(z), junk(op), junk(fn), e);
  endtask

  task automatic idle_fetch(input string nm);
    ctl_t e;
    e = '0; e.mem_read = 1'b1;
    step(nm, 1'b1, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h3F, e);
  endtask

  initial begin
    logic [5:0] ops [14];
    logic [5:0] fns [11];
    ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0F,
            6'h23, 6'h23, 6'h2B, 6'h2B, 6'h3F};
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20, 6'h21, 6'h2A, 6'h01};
    bus.Opcode = '0; bus.Function_opcode = '0; bus.Zero = 1'b0; bus.mem_ready = 1'b0;

    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, '0);
    step("reset", 1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 6'h00, '0);

    noise = 1'b0;
    run_instr(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);  // add
    run_instr(6'h23, 6'h11, 1'b0, 0, 2, 1'b0);  // lw, two MEM wait cycles
    run_instr(6'h04, 6'h00, 1'b1, 0, 0, 1'b0);  // beq taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0, 1'b0);  // bne not taken
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, 1'b0);  // illegal
    run_instr(6'h2B, 6'h00, 1'b0, 1, 1, 1'b1);  // sw aborted by reset in MEM wait
    run_instr(6'h02, 6'h00, 1'b0, 0, 0, 1'b0);  // j
    run_instr(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);  // jal
    run_instr(6'h00, 6'h08, 1'b0, 0, 0, 1'b0);  // jr
    run_instr(6'h00, 6'h00, 1'b0, 0, 0, 1'b0);  // sll
    idle_fetch("after_seq");

    noise = 1'b1;
    repeat (250) begin
      logic [5:0] op, fn;
      int         wm;
      op = ops[$urandom_range(0, 13)];
      if (op == 6'h3F) op = 6'($urandom);
      if (op == 6'h08) op = 6'($urandom_range(8, 15));
      fn = fns[$urandom_range(0, 10)];
      if (fn == 6'h01) fn = 6'($urandom);
      wm = $urandom_range(0, 2);
      run_instr(op, fn, 1'($urandom), $urandom_range(0, 2), wm,
                (wm > 0) && ($urandom_range(0, 7) == 0));
    end
    idle_fetch("final");

    @(negedge clock);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
